// File: rtl/state_step_sequencer.sv
// Command-driven 4-bit state stepper feeding the next-state register stage.
// Optional feature macro: STATE_STEP_SEQUENCER_GRAY_EN (Gray-code stepping instead of binary).
module state_step_sequencer #(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] RESET_STATE = 4'd12
) (
    input  logic       ClkA,
    input  logic       Reset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [1:0] CmdOp,
    input  logic [3:0] CmdData,
    output logic [3:0] CurrentState,
    output logic       Wrap,
    output logic       Busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} fsm_t;

    logic [5:0]    fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fsm_t          fsm_q, fsm_d;
    logic [3:0]    state_q, state_d, rem_q, rem_d;
    logic          dir_up_q, dir_up_d, wrap_q, wrap_d, busy_q, busy_d;
    logic          push, pop;
    logic [1:0]    head_op;
    logic [3:0]    head_n;

`ifdef STATE_STEP_SEQUENCER_GRAY_EN
    function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] step_fn(input logic [3:0] s, input logic up);
        logic [3:0] b;
        b = gray_to_bin(s);
        b = up ? b + 4'd1 : b - 4'd1;
        return b ^ {1'b0, b[3:1]};
    endfunction

    // Gray(15) = 1000 and Gray(0) = 0000 mark the sequence ends.
    function automatic logic wrap_fn(input logic [3:0] s, input logic up);
        return up ? (s == 4'b1000) : (s == 4'b0000);
    endfunction
`else
    function automatic logic [3:0] step_fn(input logic [3:0] s, input logic up);
        return up ? s + 4'd1 : s - 4'd1;
    endfunction

    function automatic logic wrap_fn(input logic [3:0] s, input logic up);
        return up ? (s == 4'd15) : (s == 4'd0);
    endfunction
`endif

    assign CmdReady     = (count_q != FULL_CNT);
    assign CurrentState = state_q;
    assign Wrap         = wrap_q;
    assign Busy         = busy_q;

    always_comb begin
        push              = CmdValid && CmdReady;
        pop               = (fsm_q == ST_IDLE) && (count_q != '0);
        {head_op, head_n} = fifo_q[rd_ptr_q];
        state_d           = state_q;
        rem_d             = rem_q;
        fsm_d             = fsm_q;
        dir_up_d          = dir_up_q;
        wrap_d            = 1'b0;
        wr_ptr_d          = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d          = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case (fsm_q)
            ST_IDLE: begin
                // LOAD always loads; counted ops with N = 0 only burn the pop cycle.
                if (pop) begin
                    if (head_op == OP_LOAD) begin
                        state_d = head_n;
                    end else if (head_n != 4'd0) begin
                        rem_d = head_n - 4'd1;
                        if (head_op != OP_HOLD) begin
                            dir_up_d = (head_op == OP_UP);
                            state_d  = step_fn(state_q, dir_up_d);
                            wrap_d   = wrap_fn(state_q, dir_up_d);
                            if (head_n != 4'd1) fsm_d = ST_RUN;
                        end else if (head_n != 4'd1) begin
                            fsm_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_RUN: begin
                state_d = step_fn(state_q, dir_up_q);
                wrap_d  = wrap_fn(state_q, dir_up_q);
                rem_d   = rem_q - 4'd1;
                if (rem_q == 4'd1) fsm_d = ST_IDLE;
            end
            ST_WAIT: begin
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        busy_d = (fsm_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge ClkA) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fsm_q    <= ST_IDLE;
            state_q  <= RESET_STATE;
            rem_q    <= 4'd0;
            dir_up_q <= 1'b1;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            dir_up_q <= dir_up_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge ClkA) begin
        if (push && !Reset) fifo_q[wr_ptr_q] <= {CmdOp, CmdData};
    end
endmodule

// File: doc/state_step_sequencer.md
# state_step_sequencer

- Generates the 4-bit `CurrentState` word consumed by the next-state register stage.
- Accepts commands over a valid/ready port into a small FIFO and executes them one at a time: load, count up, count down, or hold for N cycles.
- Drives `CurrentState` every cycle, and raises a wrap flag when counting crosses the 15/0 boundary.

## Interface
- `DEPTH`, default 4: command FIFO depth. Legal values are 2, 4 or 8.
- `RESET_STATE`, default 12: value of `CurrentState` after reset. It matches the downstream register's reset load.
- `ClkA` input, 1 bit: the only clock. All logic updates on its rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `CmdValid` input, 1 bit: a command is present on `CmdOp`/`CmdData`.
- `CmdReady` output, 1 bit: FIFO can accept a command.
- `CmdOp` input, 2 bits: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `CmdData` input, 4 bits: the load value (LOAD) or the count N (UP/DOWN/HOLD).
- `CurrentState` output, 4 bits: registered state word to the downstream stage.
- `Wrap` output, 1 bit: registered one-cycle pulse on a boundary crossing.
- `Busy` output, 1 bit: FSM not IDLE, or FIFO non-empty.

## Operation
**Reset**
- Reset is sampled only at a `ClkA` edge.
- It empties the FIFO and puts the FSM in IDLE.
- Output values after reset: `CurrentState` = `RESET_STATE`, `Wrap` = 0, `Busy` = 0, `CmdReady` = 1.
- Reset has priority over every other event, including a command mid-run or a push in the same cycle.

**Command FIFO**
- Each entry is 6 bits: `{op, data}`.
- Push when `CmdValid && CmdReady`.
- `CmdReady` = !full. It depends only on registered occupancy, with no combinational path from `CmdValid`.
- A push while full is impossible by construction. A pop while full frees the slot at the next edge, not the same cycle.

**FSM states**
- IDLE: if the FIFO is non-empty at an edge, pop the head and act on it at that same edge:
  - LOAD: `CurrentState` <= data; stay in IDLE.
  - UP or DOWN with N ≥ 1: `CurrentState` <= state ± 1 (mod 16), remaining <= N−1. Go to RUN if remaining > 0, else stay in IDLE.
  - HOLD with N ≥ 1: state unchanged, remaining <= N−1. Go to WAIT if remaining > 0.
  - Any op with N = 0: no-op that consumes one pop cycle.
- RUN: each edge, step ± 1 and decrement remaining. Return to IDLE at the edge where remaining reaches 0. No pops occur in RUN.
- WAIT: each edge, decrement remaining with state unchanged. Return to IDLE when remaining reaches 0.

**Arithmetic**
- 4-bit modulo-16 stepping, with no saturation.
- The remaining-count register is 4 bits.

**Wrap**
- Goes high for exactly the cycle after any edge where the state stepped 15→0 (UP) or 0→15 (DOWN).
- LOAD never asserts `Wrap`, even when the load value is 0 or 15.

## Timing
- Command accepted at edge t with FIFO empty and FSM IDLE: popped at edge t+1, so the first `CurrentState` change is visible after t+1.
- UP/DOWN with count N: N consecutive updates on edges t+1 … t+N.
- The next command pops at edge t+N+1. There is no bubble between back-to-back commands.
- HOLD with count N: the FSM occupies N edges, then pops the next command.
- `Busy` is registered. It rises the cycle after the first push and falls the cycle after the final command completes with the FIFO empty.
- Reset mid-RUN: the in-flight count is lost. `CurrentState` = `RESET_STATE` the cycle after the reset edge.

## Configuration
- `STATE_STEP_SEQUENCER_GRAY_EN` defined:
  - UP/DOWN step through the 4-bit reflected Gray sequence instead of binary.
  - Binary index i+1 is presented as Gray(i+1); LOAD data is taken as already Gray-coded.
  - `Wrap` fires on the Gray 1000→0000 transition (UP) or 0000→1000 transition (DOWN).
- Not defined: plain binary stepping as described above. No Gray logic is synthesised.

## Test plan
- **Reset value:** assert `Reset` for 2 cycles → `CurrentState` = 12, `Wrap` = 0, `Busy` = 0, `CmdReady` = 1. Assert `Reset` again during an UP 10 → state returns to 12 and the FIFO is empty.
- **LOAD then UP:** LOAD 14, then UP 3 → `CurrentState` sequence 14, 15, 0, 1. `Wrap` is high for exactly one cycle, the cycle after the 15→0 edge.
- **DOWN across zero:** LOAD 1, then DOWN 2 → states 0, 15. `Wrap` pulses once, after the 0→15 edge.
- **HOLD and zero count:** LOAD 5, HOLD 4, UP 0, UP 1 → state stays 5 for 4 cycles plus the one no-op pop cycle, then becomes 6.
- **Backpressure:** push DEPTH+2 commands while UP 15 runs → `CmdReady` drops after DEPTH accepts. No command is lost or duplicated, and the final state equals the scoreboard model.
- **Gray mode:** with `STATE_STEP_SEQUENCER_GRAY_EN`, LOAD 0 then UP 4 → states 0001, 0011, 0010, 0110.
